// File: rtl/inst_queue.sv
// Dual-issue fetch->ID instruction FIFO, 1-cycle enqueue-to-visible latency, no empty bypass; in_ready
// drops when fewer than 2 slots are free, flush empties the queue. IQ_PERF_EN adds full/empty perf counters.
module inst_queue #(
  parameter int DEPTH   = 16,
  parameter int PC_W    = 64,
  parameter int INSTR_W = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [1:0]               in_valid,
  input  logic [2*PC_W-1:0]        in_pc,
  input  logic [2*INSTR_W-1:0]     in_instr,
  output logic                     in_ready,
  input  logic                     stall_id,
  input  logic                     flush_id,
  input  logic [1:0]               issue_num,
  output logic [1:0]               out_valid,
  output logic [2*PC_W-1:0]        out_pc,
  output logic [2*INSTR_W-1:0]     out_instr,
  output logic [$clog2(DEPTH):0]   count
`ifdef IQ_PERF_EN
  ,
  output logic [31:0]              perf_full_cycles,
  output logic [31:0]              perf_empty_cycles
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [PC_W-1:0]    pc_q    [DEPTH];
  logic [INSTR_W-1:0] instr_q [DEPTH];

  logic [AW-1:0] head_q, head_d, tail_q, tail_d;
  logic [AW-1:0] head_p1, tail_p1;
  logic [CW-1:0] count_q, count_d;
  logic [1:0]    enq_num, deq_req, deq_num;

  assign head_p1  = head_q + AW'(1);
  assign tail_p1  = tail_q + AW'(1);
  // Ready looks only at registered occupancy, so there is no dequeue-to-ready path.
  assign in_ready = (count_q <= CW'(DEPTH - 2));

  always_comb begin
    enq_num = in_ready ? ({1'b0, in_valid[0]} + {1'b0, in_valid[1]}) : 2'd0;
    deq_req = stall_id ? 2'd0 : issue_num;
    deq_num = (CW'(deq_req) > count_q) ? count_q[1:0] : deq_req;
    head_d  = head_q + AW'(deq_num);
    tail_d  = tail_q + AW'(enq_num);
    count_d = count_q + CW'(enq_num) - CW'(deq_num);
    if (flush_id) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry contents carry no reset; occupancy alone qualifies them.
  always_ff @(posedge clk) begin
    if (!rst && !flush_id) begin
      if (enq_num != 2'd0) begin
        pc_q[tail_q]    <= in_pc[0 +: PC_W];
        instr_q[tail_q] <= in_instr[0 +: INSTR_W];
      end
      if (enq_num == 2'd2) begin
        pc_q[tail_p1]    <= in_pc[PC_W +: PC_W];
        instr_q[tail_p1] <= in_instr[INSTR_W +: INSTR_W];
      end
    end
  end

  assign out_valid = {(count_q >= CW'(2)), (count_q != '0)};
  assign out_pc    = {pc_q[head_p1], pc_q[head_q]};
  assign out_instr = {instr_q[head_p1], instr_q[head_q]};
  assign count     = count_q;

  always @(posedge clk) begin
    if (!rst && !flush_id && !stall_id)
      assert (CW'(issue_num) <= count_q)
        else $warning("inst_queue: issue_num %0d exceeds occupancy %0d, clamped", issue_num, count_q);
  end

`ifdef IQ_PERF_EN
  logic [31:0] perf_full_q, perf_empty_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_full_q  <= '0;
      perf_empty_q <= '0;
    end else begin
      if (!in_ready && (in_valid != 2'b00) && (perf_full_q != '1))
        perf_full_q <= perf_full_q + 32'd1;
      if ((count_q == '0) && !flush_id && (perf_empty_q != '1))
        perf_empty_q <= perf_empty_q + 32'd1;
    end
  end

  assign perf_full_cycles  = perf_full_q;
  assign perf_empty_cycles = perf_empty_q;
`endif

endmodule

// File: tb/tb_inst_queue.sv
// Scoreboard bench for inst_queue: accepted fetch slots are queued, dequeued slots are checked in order.
module tb_inst_queue;
  localparam int DEPTH   = 16;
  localparam int PC_W    = 64;
  localparam int INSTR_W = 32;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [1:0]           in_valid;
  logic [2*PC_W-1:0]    in_pc;
  logic [2*INSTR_W-1:0] in_instr;
  logic                 in_ready;
  logic                 stall_id, flush_id;
  logic [1:0]           issue_num;
  logic [1:0]           out_valid;
  logic [2*PC_W-1:0]    out_pc;
  logic [2*INSTR_W-1:0] out_instr;
  logic [4:0]           count;
`ifdef IQ_PERF_EN
  logic [31:0]          perf_full_cycles, perf_empty_cycles;
`endif

  always #5 clk = ~clk;

  inst_queue #(.DEPTH(DEPTH), .PC_W(PC_W), .INSTR_W(INSTR_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_pc(in_pc), .in_instr(in_instr), .in_ready(in_ready),
    .stall_id(stall_id), .flush_id(flush_id), .issue_num(issue_num),
    .out_valid(out_valid), .out_pc(out_pc), .out_instr(out_instr), .count(count)
`ifdef IQ_PERF_EN
    , .perf_full_cycles(perf_full_cycles), .perf_empty_cycles(perf_empty_cycles)
`endif
  );

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
  } ent_t;

  ent_t        sb[$];
  logic [63:0] next_pc;
  int          n_tests = 0;
  int          n_fail  = 0;

  function automatic logic [31:0] mk_instr(input logic [63:0] pc);
    return pc[31:0] ^ 32'h5a5a_0013;
  endfunction

  // One clock of stimulus; dequeued entries are popped and compared against the head slots.
  task automatic cycle(input logic [1:0] iv, input logic st, input logic fl, input logic [1:0] iss);
    int   deq, room;
    ent_t e;
    @(negedge clk);
    rst = 1'b0; in_valid = iv; stall_id = st; flush_id = fl; issue_num = iss;
    in_pc    = {next_pc + 64'd4, next_pc};
    in_instr = {mk_instr(next_pc + 64'd4), mk_instr(next_pc)};
    #1;
    room = DEPTH - sb.size();
    if (!fl && !st) begin
      deq = (int'(iss) > sb.size()) ? sb.size() : int'(iss);
      for (int i = 0; i < deq; i++) begin
        e = sb.pop_front();
        n_tests++;
        if (out_pc[i*PC_W +: PC_W] !== e.pc || out_instr[i*INSTR_W +: INSTR_W] !== e.instr ||
            out_valid[i] !== 1'b1) begin
          n_fail++;
          $display("FAIL deq_slot%0d: got pc=%h instr=%h vld=%b, want pc=%h instr=%h vld=1",
                   i, out_pc[i*PC_W +: PC_W], out_instr[i*INSTR_W +: INSTR_W], out_valid[i], e.pc, e.instr);
        end
      end
    end
    if (fl) sb.delete();
    else if (room >= 2 && iv != 2'b00) begin
      sb.push_back('{pc: next_pc, instr: mk_instr(next_pc)});
      if (iv[1]) sb.push_back('{pc: next_pc + 64'd4, instr: mk_instr(next_pc + 64'd4)});
      next_pc = next_pc + (iv[1] ? 64'd8 : 64'd4);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; in_valid = 2'b00; stall_id = 1'b0; flush_id = 1'b0; issue_num = 2'd0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    sb.delete();
  endtask

  task automatic test_reset();
    do_reset();
    n_tests++;
    if (count !== 5'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", count); end
    n_tests++;
    if (out_valid !== 2'b00) begin n_fail++; $display("FAIL reset_out_valid: got %b want 00", out_valid); end
    n_tests++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_fill();
    next_pc = 64'h8000_0000;
    for (int k = 0; k < 8; k++) cycle(2'b11, 1'b1, 1'b0, 2'd0);
    n_tests++;
    if (count !== 5'd16) begin n_fail++; $display("FAIL fill_count: got %0d want 16", count); end
    n_tests++;
    if (in_ready !== 1'b0) begin n_fail++; $display("FAIL fill_in_ready: got %b want 0", in_ready); end
    n_tests++;
    if (out_valid !== 2'b11) begin n_fail++; $display("FAIL fill_out_valid: got %b want 11", out_valid); end
    n_tests++;
    if (out_pc[63:0] !== 64'h8000_0000 || out_pc[127:64] !== 64'h8000_0004) begin
      n_fail++;
      $display("FAIL fill_head_pcs: got %h/%h want 80000000/80000004", out_pc[63:0], out_pc[127:64]);
    end
  endtask

  // At full in_ready is low, so the first cycle only drains; after that 2-in/2-out holds count at 14.
  task automatic test_dual_drain_wrap();
    logic [63:0] exp_pc;
    for (int k = 0; k < 8; k++) begin
      cycle(2'b11, 1'b0, 1'b0, 2'd2);
      exp_pc = 64'h8000_0000 + 64'(8 * (k + 1));
      n_tests++;
      if (count !== 5'd14) begin n_fail++; $display("FAIL drain_count[%0d]: got %0d want 14", k, count); end
      n_tests++;
      if (out_pc[63:0] !== exp_pc) begin
        n_fail++; $display("FAIL drain_head_pc[%0d]: got %h want %h", k, out_pc[63:0], exp_pc);
      end
    end
  endtask

  task automatic test_load_use_stall();
    logic [63:0] held_pc;
    for (int k = 0; k < 8 && sb.size() > 4; k++) cycle(2'b00, 1'b0, 1'b0, 2'd2);
    n_tests++;
    if (count !== 5'd4) begin n_fail++; $display("FAIL stall_setup_count: got %0d want 4", count); end
    held_pc = sb[0].pc;
    for (int k = 0; k < 3; k++) begin
      cycle(2'b00, 1'b1, 1'b0, 2'd2);
      n_tests++;
      if (count !== 5'd4 || out_pc[63:0] !== held_pc) begin
        n_fail++; $display("FAIL stall_hold[%0d]: got count=%0d pc=%h want 4/%h", k, count, out_pc[63:0], held_pc);
      end
    end
    cycle(2'b00, 1'b0, 1'b0, 2'd2);
    n_tests++;
    if (count !== 5'd2) begin n_fail++; $display("FAIL stall_release1: got %0d want 2", count); end
    cycle(2'b00, 1'b0, 1'b0, 2'd2);
    n_tests++;
    if (count !== 5'd0) begin n_fail++; $display("FAIL stall_release2: got %0d want 0", count); end
  endtask

  task automatic test_flush();
    for (int k = 0; k < 3; k++) cycle(2'b11, 1'b1, 1'b0, 2'd0);
    n_tests++;
    if (count !== 5'd6) begin n_fail++; $display("FAIL flush_setup_count: got %0d want 6", count); end
    cycle(2'b11, 1'b1, 1'b1, 2'd2);
    n_tests++;
    if (count !== 5'd0 || out_valid !== 2'b00 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL flush_state: got count=%0d vld=%b rdy=%b want 0/00/1", count, out_valid, in_ready);
    end
    cycle(2'b00, 1'b0, 1'b0, 2'd0);
    n_tests++;
    if (count !== 5'd0) begin n_fail++; $display("FAIL flush_pair_absent: got %0d want 0", count); end
  endtask

  task automatic test_single_slot();
    cycle(2'b01, 1'b1, 1'b0, 2'd0);
    cycle(2'b01, 1'b0, 1'b0, 2'd1);
    n_tests++;
    if (count !== 5'd1 || out_valid !== 2'b01) begin
      n_fail++; $display("FAIL single_hold: got count=%0d vld=%b want 1/01", count, out_valid);
    end
    n_tests++;
    if (out_pc[63:0] !== sb[0].pc || out_pc[63:0] !== next_pc - 64'd4) begin
      n_fail++; $display("FAIL single_new_pc: got %h want %h", out_pc[63:0], next_pc - 64'd4);
    end
    cycle(2'b00, 1'b0, 1'b0, 2'd2);
    n_tests++;
    if (count !== 5'd0 || out_valid !== 2'b00) begin
      n_fail++; $display("FAIL single_clamp: got count=%0d vld=%b want 0/00", count, out_valid);
    end
  endtask

`ifdef IQ_PERF_EN
  task automatic test_perf();
    do_reset();
    for (int k = 0; k < 8; k++) cycle(2'b11, 1'b1, 1'b0, 2'd0);
    for (int k = 0; k < 10; k++) cycle(2'b11, 1'b1, 1'b0, 2'd0);
    n_tests++;
    if (perf_full_cycles !== 32'd10) begin n_fail++; $display("FAIL perf_full: got %0d want 10", perf_full_cycles); end
    n_tests++;
    if (perf_empty_cycles !== 32'd1) begin n_fail++; $display("FAIL perf_empty: got %0d want 1", perf_empty_cycles); end
    cycle(2'b00, 1'b1, 1'b1, 2'd0);
    n_tests++;
    if (perf_full_cycles !== 32'd10) begin n_fail++; $display("FAIL perf_flush_keep: got %0d want 10", perf_full_cycles); end
    do_reset();
    n_tests++;
    if (perf_full_cycles !== 32'd0 || perf_empty_cycles !== 32'd0) begin
      n_fail++; $display("FAIL perf_reset: got %0d/%0d want 0/0", perf_full_cycles, perf_empty_cycles);
    end
  endtask
`endif

  initial begin
    rst = 1'b1; in_valid = 2'b00; stall_id = 1'b0; flush_id = 1'b0; issue_num = 2'd0;
    in_pc = '0; in_instr = '0; next_pc = 64'h8000_0000;
    test_reset();
    test_fill();
    test_dual_drain_wrap();
    test_load_use_stall();
    test_flush();
    test_single_slot();
`ifdef IQ_PERF_EN
    test_perf();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
